// File: rtl/gsim_pkg.sv
// Shared types and band constants for the GSIM Gauss-Seidel solver family.
// The row equation is 20*x_i - 13*(x_i±1) + 6*(x_i±2) - (x_i±3) = b_i.
package gsim_pkg;

  typedef enum logic [1:0] {
    RECEIVE = 2'd0,
    CALC    = 2'd1,
    SEND    = 2'd2
  } state_t;

  localparam int C_DIAG = 20;
  localparam int C_N1   = 13;
  localparam int C_N2   = 6;
  localparam int C_N3   = 1;
  localparam int BAND   = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/gsim_row_update.sv
// One Gauss-Seidel row update: (b<<<FRAC + weighted neighbours) / 20, saturated,
// plus |x_new - x_old| for convergence tracking. Purely combinational.
module gsim_row_update
  import gsim_pkg::*;
#(
  parameter int B_W  = 16,
  parameter int X_W  = 32,
  parameter int FRAC = 16
) (
  input  logic signed [B_W-1:0]            b_i,
  input  logic [2*BAND-1:0][X_W-1:0]       nbr,     // {i+3,i-3,i+2,i-2,i+1,i-1}
  input  logic [2*BAND-1:0]                nbr_ok,
  input  logic [X_W-1:0]                   x_old,
  output logic [X_W-1:0]                   x_new,
  output logic [X_W:0]                     delta
);

  localparam int NW = X_W + 8;
  localparam logic signed [NW-1:0] K0 = NW'(C_DIAG);
  localparam logic signed [NW-1:0] K1 = NW'(C_N1);
  localparam logic signed [NW-1:0] K2 = NW'(C_N2);
  localparam logic signed [NW-1:0] K3 = NW'(C_N3);
  localparam logic signed [NW-1:0] XMAX = {{(NW-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [NW-1:0] XMIN = {{(NW-X_W+1){1'b1}}, {(X_W-1){1'b0}}};

  logic signed [NW-1:0] nv [2*BAND];
  logic signed [NW-1:0] bx, num, q;
  logic signed [X_W:0]  diff;

  always_comb begin
    for (int k = 0; k < 2*BAND; k++)
      nv[k] = nbr_ok[k] ? NW'(signed'(nbr[k])) : '0;
  end

  // NW bits leave headroom for 40*|x|max + b<<<FRAC, so no intermediate wraps
  assign bx  = NW'(b_i) <<< FRAC;
  assign num = bx + K1 * (nv[0] + nv[1]) - K2 * (nv[2] + nv[3]) + K3 * (nv[4] + nv[5]);
  assign q   = num / K0;

  always_comb begin
    if (q > XMAX)      x_new = {1'b0, {(X_W-1){1'b1}}};
    else if (q < XMIN) x_new = {1'b1, {(X_W-1){1'b0}}};
    else               x_new = q[X_W-1:0];
  end

  assign diff  = {x_new[X_W-1], x_new} - {x_old[X_W-1], x_old};
  assign delta = diff[X_W] ? (~diff + (X_W+1)'(1)) : diff;

endmodule

// File: rtl/gsim_param.sv
// Parametrised iterative Gauss-Seidel solver: streams in b, sweeps rows one per
// cycle until the max per-sweep change is within tol or the sweep limit is hit.
module gsim_param
  import gsim_pkg::*;
#(
  parameter int N        = 16,
  parameter int B_W      = 16,
  parameter int X_W      = 32,
  parameter int FRAC     = 16,
  parameter int MAX_ITER = 200
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [B_W-1:0]             b_in,
  input  logic [clog2(MAX_ITER+1)-1:0]      iter_limit,
  input  logic [X_W-1:0]                    tol,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [X_W-1:0]                    x_out,
  output logic [clog2(N)-1:0]               x_idx,
  output logic [clog2(MAX_ITER+1)-1:0]      iter_count,
  output logic                              converged
);

  localparam int IW   = clog2(N);
  localparam int IC_W = clog2(MAX_ITER+1);
  localparam logic [IC_W-1:0] MAXI = IC_W'(MAX_ITER);

  state_t state, state_nx;

  logic [IW-1:0]          idx;
  logic [IC_W-1:0]        lim_q, lim_in;
  logic [X_W-1:0]         tol_q;
  logic [X_W:0]           max_d, max_inc;
  logic [X_W-1:0]         x_mem [N];
  logic signed [B_W-1:0]  b_mem [N];

  logic [2*BAND-1:0][X_W-1:0] nbr;
  logic [2*BAND-1:0]          nbr_ok;
  logic [X_W-1:0]             x_new;
  logic [X_W:0]               delta;

  logic accept, first, last_in, last_row, last_out, done_tol, done_lim;

  assign in_ready  = (state == RECEIVE);
  assign out_valid = (state == SEND);
  assign x_out     = x_mem[x_idx];

  assign accept   = in_valid && in_ready;
  assign first    = accept && (idx == '0);
  assign last_in  = accept && (idx == IW'(N-1));
  assign last_row = (state == CALC) && (idx == IW'(N-1));
  assign last_out = out_valid && out_ready && (x_idx == IW'(N-1));

  assign lim_in   = (iter_limit == '0 || iter_limit > MAXI) ? MAXI : iter_limit;
  // Max is restarted at row 0 so each sweep is judged on its own changes
  assign max_inc  = (idx == '0 || delta > max_d) ? delta : max_d;
  assign done_tol = (max_inc <= {1'b0, tol_q});
  assign done_lim = ({1'b0, iter_count} + (IC_W+1)'(1)) >= {1'b0, lim_q};

  // Neighbour fetch straight from the live x array, so rows below i are already new
  for (genvar d = 1; d <= BAND; d++) begin : g_nbr
    assign nbr_ok[2*d-2] = (int'(idx) >= d);
    assign nbr_ok[2*d-1] = (int'(idx) + d < N);
    assign nbr[2*d-2]    = nbr_ok[2*d-2] ? x_mem[idx - IW'(d)] : '0;
    assign nbr[2*d-1]    = nbr_ok[2*d-1] ? x_mem[idx + IW'(d)] : '0;
  end

  gsim_row_update #(
    .B_W  (B_W),
    .X_W  (X_W),
    .FRAC (FRAC)
  ) u_row (
    .b_i    (b_mem[idx]),
    .nbr    (nbr),
    .nbr_ok (nbr_ok),
    .x_old  (x_mem[idx]),
    .x_new  (x_new),
    .delta  (delta)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RECEIVE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      RECEIVE: if (last_in) state_nx = CALC;
      CALC:    if (last_row && (done_tol || done_lim)) state_nx = SEND;
      SEND:    if (last_out) state_nx = RECEIVE;
      default: state_nx = RECEIVE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx        <= '0;
      x_idx      <= '0;
      iter_count <= '0;
      converged  <= 1'b0;
      lim_q      <= '0;
      tol_q      <= '0;
      max_d      <= '0;
      for (int k = 0; k < N; k++) begin
        x_mem[k] <= '0;
        b_mem[k] <= '0;
      end
    end else begin
      case (state)
        RECEIVE: if (accept) begin
          b_mem[idx] <= b_in;
          idx        <= last_in ? '0 : idx + IW'(1);
          if (first) begin
            lim_q      <= lim_in;
            tol_q      <= tol;
            iter_count <= '0;
            converged  <= 1'b0;
            for (int k = 0; k < N; k++) x_mem[k] <= '0;
          end
        end
        CALC: begin
          x_mem[idx] <= x_new;
          max_d      <= max_inc;
          if (last_row) begin
            idx        <= '0;
            iter_count <= iter_count + IC_W'(1);
            converged  <= done_tol;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        SEND: if (out_ready) x_idx <= (x_idx == IW'(N-1)) ? '0 : x_idx + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gsim_param.md
Name: gsim_param

Overview:
- Parametrised iterative Gauss-Seidel solver for the N-unknown banded system used by the GSIM family.
- Row i: 20*x_i - 13*(x_{i-1}+x_{i+1}) + 6*(x_{i-2}+x_{i+2}) - (x_{i-3}+x_{i+3}) = b_i.
- Successor features: generic size, valid/ready on both sides, runtime iteration limit, early exit on a convergence tolerance, and status outputs.
- Sits between the b-vector loader and the result collector.

Parameters:
- N, 16, number of unknowns (legal 4..64).
- B_W, 16, signed width of b_in.
- X_W, 32, signed width of x values.
- FRAC, 16, fractional bits of x; b is integer and enters as b<<<FRAC.
- MAX_ITER, 200, hard sweep limit; also sets the width of iter_count.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  b_in is valid this cycle.
- in_ready  out  1  block accepts b_in.
- b_in  in  B_W  b_i, presented in index order 0..N-1.
- iter_limit  in  clog2(MAX_ITER+1)  sweep limit; sampled on the first accepted b.
- tol  in  X_W  unsigned convergence threshold; sampled on the first accepted b.
- out_valid  out  1  x_out is valid.
- out_ready  in  1  downstream accepts x_out.
- x_out  out  X_W  x_i, emitted in order 0..N-1.
- x_idx  out  clog2(N)  index of the current x_out.
- iter_count  out  clog2(MAX_ITER+1)  number of completed sweeps of the last solve.
- converged  out  1  last solve exited on tolerance.

Behaviour:
- Interface decision: one clock, clk; reset_n is asynchronous and active-low.
- Reset values:
  - State RECEIVE; in_ready=1; out_valid=0.
  - x_out=0, x_idx=0, iter_count=0, converged=0.
  - All x and b storage = 0.
- Reset asserted at any time, including mid-CALC or mid-SEND, aborts the solve immediately. No partial output follows.
- RECEIVE:
  - in_ready=1.
  - Each in_valid&in_ready cycle stores b_in at the current index and increments the index.
  - The first accept latches iter_limit and tol, clears all x to 0, and clears iter_count and converged.
  - After the N-th accept, enter CALC on the next cycle; in_ready=0 outside RECEIVE.
- Iteration limit: a latched iter_limit of 0 means MAX_ITER; values above MAX_ITER clamp to MAX_ITER.
- CALC: exactly one row update per cycle, i = 0..N-1 ascending, so one sweep takes N cycles.
- Row update (true Gauss-Seidel): each update uses the current x array, including values written earlier in the same sweep.
  - num = (b_i<<<FRAC) + 13*(x_{i-1}+x_{i+1}) - 6*(x_{i-2}+x_{i+2}) + (x_{i-3}+x_{i+3}).
  - Neighbours outside 0..N-1 contribute 0.
  - num is computed at X_W+8 bits with sign extension, so there is no internal overflow.
  - x_new = num/20, signed division truncating toward zero.
  - x_new saturates to the X_W signed range.
- Delta tracking: delta = |x_new - x_old| at X_W+1 bits. A running max delta is held per sweep and cleared at i=0.
- End of sweep (i=N-1 cycle): iter_count increments. On the next cycle:
  - If max delta (including row N-1) <= tol: converged=1, go to SEND.
  - Else if iter_count reaches the latched limit: converged=0, go to SEND.
  - Else start the next sweep.
- Minimum CALC duration is N cycles.
- SEND:
  - out_valid=1; x_out = x[x_idx].
  - x_idx advances on out_valid&out_ready. x_out and x_idx stay stable while out_ready=0.
  - After the handshake of index N-1: out_valid=0 on the next cycle, return to RECEIVE.
  - iter_count and converged hold until the next first-accept.
- in_valid outside RECEIVE is ignored. b is never overwritten during CALC or SEND.

Decomposition:
- Package gsim_pkg holds:
  - state enum RECEIVE/CALC/SEND;
  - band coefficients 20, 13, 6, 1 and band half-width 3;
  - a clog2 helper.
- One sub-module, gsim_row_update: purely combinational. Inputs are b_i, six neighbour values with in-range masks, and x_old. Outputs are x_new (saturated) and delta.
- The top level holds the FSM, counters, x/b storage, and the max-delta register.

Test Plan:
- All b=0, tol=0, iter_limit=5 -> all x=0, converged=1, iter_count=1; CALC lasts exactly 16 cycles.
- b_0=20, others 0, iter_limit=1, tol=0 -> converged=0, iter_count=1:
  - x_0=0x00010000, x_1=42598, x_2=8027;
  - remaining words match the golden model bit-exact.
- Random b in [-32768, 32767], iter_limit=0, tol=0 -> runs to 200 sweeps or converges earlier; all 16 words match the golden model bit-exact; iter_count matches the model.
- out_ready toggled pseudo-randomly during SEND -> exactly 16 words in index order 0..15, x_out stable while stalled, no duplicates or skips.
- Reset pulse during sweep 3 of CALC, then a new problem -> outputs at reset values, in_ready=1 after release, new result correct with x starting from 0.
- in_valid held high continuously across two back-to-back problems -> b accepted only in RECEIVE, both results correct, the second problem's parameters latched independently.
